// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl: IF-stage fetch sequencer.
// Owns the fetch PC, keeps at most one I-cache request outstanding, picks the
// 32-bit word out of the returned 64-bit block and writes it to the fetch
// buffer. Handles buffer back-pressure and branch redirects, including
// discarding a response that was already in flight when the redirect hit.
// Optional build macro: IF_FETCH_CTRL_PERF_EN adds fetch/stall counters.
//
// state | meaning
// IDLE  | first cycle after reset, no request yet
// REQ   | presenting the PC to the I-cache until granted
// WAIT  | request granted, waiting for the response
// DRAIN | response still owed for a flushed request; discard it
// HOLD  | response captured while the buffer was full; waiting to write it
module if_fetch_ctrl #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        icache_req_o,
  output logic [63:0] icache_addr_o,
  input  logic        icache_gnt_i,
  input  logic        icache_vld_i,
  input  logic [63:0] icache_data_i,
  input  logic        br_redirect_i,
  input  logic [63:0] br_target_i,
  input  logic        ifb_full_i,
  output logic        ifb_en_o,
  output logic [31:0] ifb_insn_o,
  output logic [63:0] ifb_PC_o,
  output logic        ifb_flush_o
`ifdef IF_FETCH_CTRL_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt_o,
  output logic [31:0] perf_stall_cnt_o
`endif
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    DRAIN = 3'd3,
    HOLD  = 3'd4
  } state_t;

  state_t      state;
  logic [63:0] pc;
  logic [63:0] hold_pc;
  logic [31:0] hold_insn;

  logic [63:0] redir_pc;
  logic [31:0] sel_insn;
  logic        rsp_write;
  logic        hold_write;
  logic        unused_tgt_lsb;

  assign redir_pc       = {br_target_i[63:2], 2'b00};
  assign sel_insn       = pc[2] ? icache_data_i[63:32] : icache_data_i[31:0];
  assign unused_tgt_lsb = ^br_target_i[1:0];

  // A redirect always wins over a pending buffer write.
  assign rsp_write  = (state == WAIT) & icache_vld_i & ~br_redirect_i & ~ifb_full_i;
  assign hold_write = (state == HOLD) & ~br_redirect_i & ~ifb_full_i;

  // Combinational outputs; data/PC lines stay 0 whenever no write happens.
  always_comb begin
    icache_req_o  = (state == REQ) & ~ifb_full_i & ~br_redirect_i;
    icache_addr_o = icache_req_o ? {pc[63:3], 3'b000} : 64'h0;
    ifb_flush_o   = br_redirect_i;
    ifb_en_o      = rsp_write | hold_write;
    ifb_insn_o    = 32'h0;
    ifb_PC_o      = 64'h0;
    if (rsp_write) begin
      ifb_insn_o = sel_insn;
      ifb_PC_o   = pc;
    end else if (hold_write) begin
      ifb_insn_o = hold_insn;
      ifb_PC_o   = hold_pc;
    end
  end

  // Fetch FSM with PC and hold registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      hold_pc   <= 64'h0;
      hold_insn <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (br_redirect_i) pc <= redir_pc;
          state <= REQ;
        end
        REQ: begin
          if (br_redirect_i) pc <= redir_pc;
          else if (icache_req_o && icache_gnt_i) state <= WAIT;
        end
        WAIT: begin
          if (br_redirect_i) begin
            pc    <= redir_pc;
            state <= icache_vld_i ? REQ : DRAIN;
          end else if (icache_vld_i) begin
            if (ifb_full_i) begin
              hold_insn <= sel_insn;
              hold_pc   <= pc;
              state     <= HOLD;
            end else begin
              pc    <= pc + 64'd4;
              state <= REQ;
            end
          end
        end
        HOLD: begin
          if (br_redirect_i) begin
            pc    <= redir_pc;
            state <= REQ;
          end else if (!ifb_full_i) begin
            pc    <= hold_pc + 64'd4;
            state <= REQ;
          end
        end
        DRAIN: begin
          // A stale response arriving with a redirect still settles the debt.
          if (br_redirect_i) pc <= redir_pc;
          if (icache_vld_i) state <= REQ;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef IF_FETCH_CTRL_PERF_EN
  // Saturating counters of buffer writes and back-pressure stall cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt_o <= 32'h0;
      perf_stall_cnt_o <= 32'h0;
    end else begin
      if (ifb_en_o && (perf_fetch_cnt_o != 32'hFFFF_FFFF))
        perf_fetch_cnt_o <= perf_fetch_cnt_o + 32'd1;
      if (((state == REQ) || (state == HOLD)) && ifb_full_i &&
          (perf_stall_cnt_o != 32'hFFFF_FFFF))
        perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: directed vector table, a reset-during-WAIT
// sequence, then randomized traffic against a transaction-level model.
module tb_if_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        icache_req_o;
  logic [63:0] icache_addr_o;
  logic        icache_gnt_i;
  logic        icache_vld_i;
  logic [63:0] icache_data_i;
  logic        br_redirect_i;
  logic [63:0] br_target_i;
  logic        ifb_full_i;
  logic        ifb_en_o;
  logic [31:0] ifb_insn_o;
  logic [63:0] ifb_PC_o;
  logic        ifb_flush_o;
`ifdef IF_FETCH_CTRL_PERF_EN
  logic [31:0] perf_fetch_cnt_o;
  logic [31:0] perf_stall_cnt_o;
`endif

  if_fetch_ctrl #(.RESET_PC(64'h100)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .icache_req_o  (icache_req_o),
    .icache_addr_o (icache_addr_o),
    .icache_gnt_i  (icache_gnt_i),
    .icache_vld_i  (icache_vld_i),
    .icache_data_i (icache_data_i),
    .br_redirect_i (br_redirect_i),
    .br_target_i   (br_target_i),
    .ifb_full_i    (ifb_full_i),
    .ifb_en_o      (ifb_en_o),
    .ifb_insn_o    (ifb_insn_o),
    .ifb_PC_o      (ifb_PC_o),
    .ifb_flush_o   (ifb_flush_o)
`ifdef IF_FETCH_CTRL_PERF_EN
    ,
    .perf_fetch_cnt_o (perf_fetch_cnt_o),
    .perf_stall_cnt_o (perf_stall_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        full, gnt, vld;
    logic [63:0] data;
    logic        redir;
    logic [63:0] tgt;
    logic        ereq;
    logic [63:0] eaddr;
    logic        een;
    logic [31:0] einsn;
    logic [63:0] epc;
    logic        eflush;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic logic [31:0] lo(int k);
    return 32'hB000_0000 + 32'(k);
  endfunction
  function automatic logic [31:0] hi(int k);
    return 32'hA000_0000 + 32'(k);
  endfunction
  function automatic logic [63:0] dk(int k);
    return {hi(k), lo(k)};
  endfunction

  task automatic add(input logic full, gnt, vld, input logic [63:0] data,
                     input logic redir, input logic [63:0] tgt,
                     input logic ereq, input logic [63:0] eaddr, input logic een,
                     input logic [31:0] einsn, input logic [63:0] epc,
                     input logic eflush);
    vec_t v;
    v.full = full; v.gnt = gnt; v.vld = vld; v.data = data;
    v.redir = redir; v.tgt = tgt; v.ereq = ereq; v.eaddr = eaddr;
    v.een = een; v.einsn = einsn; v.epc = epc; v.eflush = eflush;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic full, gnt, vld, input logic [63:0] data,
                       input logic redir, input logic [63:0] tgt);
    ifb_full_i = full; icache_gnt_i = gnt; icache_vld_i = vld;
    icache_data_i = data; br_redirect_i = redir; br_target_i = tgt;
  endtask

  function automatic logic [162:0] act();
    return {icache_req_o, icache_addr_o, ifb_en_o, ifb_insn_o, ifb_PC_o, ifb_flush_o};
  endfunction

  task automatic chk(input string nm, input logic [162:0] a, input logic [162:0] e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got {req,addr,en,insn,pc,flush}=%h expected %h", nm, a, e);
    end
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 64'h0, 0, 64'h0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1 chk("reset_state", act(), 163'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Transaction-level reference model.
  logic        m_started, m_busy, m_stale, m_held;
  logic [63:0] m_pc, m_hpc;
  logic [31:0] m_hinsn;

  function automatic logic [31:0] pick(logic [63:0] pc, logic [63:0] d);
    return pc[2] ? d[63:32] : d[31:0];
  endfunction

  initial begin
    logic        s_pend;
    int          s_wait;
    logic        f, g, v, r;
    logic [63:0] d, t;
    logic        ereq, een;
    logic [63:0] eaddr, epc;
    logic [31:0] einsn;

    // full gnt vld data     redir tgt          req addr   en insn   pc   flush
    add(0,0,0,64'h0,  0,64'h0,             0,64'h0,   0,32'h0, 64'h0,   0);
    add(0,1,0,64'h0,  0,64'h0,             1,64'h100, 0,32'h0, 64'h0,   0);
    add(0,0,1,dk(0),  0,64'h0,             0,64'h0,   1,lo(0), 64'h100, 0);
    add(0,1,0,64'h0,  0,64'h0,             1,64'h100, 0,32'h0, 64'h0,   0);
    add(0,0,1,dk(1),  0,64'h0,             0,64'h0,   1,hi(1), 64'h104, 0);
    add(0,1,0,64'h0,  0,64'h0,             1,64'h108, 0,32'h0, 64'h0,   0);
    add(0,0,1,dk(2),  0,64'h0,             0,64'h0,   1,lo(2), 64'h108, 0);
    add(0,1,0,64'h0,  0,64'h0,             1,64'h108, 0,32'h0, 64'h0,   0);
    add(1,0,0,64'h0,  0,64'h0,             0,64'h0,   0,32'h0, 64'h0,   0);
    add(1,0,1,dk(3),  0,64'h0,             0,64'h0,   0,32'h0, 64'h0,   0);
    add(1,0,0,64'h0,  0,64'h0,             0,64'h0,   0,32'h0, 64'h0,   0);
    add(1,1,0,64'h0,  0,64'h0,             0,64'h0,   0,32'h0, 64'h0,   0);
    add(0,0,0,64'h0,  0,64'h0,             0,64'h0,   1,hi(3), 64'h10C, 0);
    add(0,1,0,64'h0,  0,64'h0,             1,64'h110, 0,32'h0, 64'h0,   0);
    add(0,0,0,64'h0,  1,64'h2003,          0,64'h0,   0,32'h0, 64'h0,   1);
    add(0,0,0,64'h0,  0,64'h0,             0,64'h0,   0,32'h0, 64'h0,   0);
    add(0,0,1,dk(4),  0,64'h0,             0,64'h0,   0,32'h0, 64'h0,   0);
    add(0,1,0,64'h0,  0,64'h0,             1,64'h2000,0,32'h0, 64'h0,   0);
    add(0,0,1,dk(5),  0,64'h0,             0,64'h0,   1,lo(5), 64'h2000,0);
    add(0,1,0,64'h0,  0,64'h0,             1,64'h2000,0,32'h0, 64'h0,   0);
    add(0,0,1,dk(6),  1,64'h3008,          0,64'h0,   0,32'h0, 64'h0,   1);
    add(0,1,0,64'h0,  0,64'h0,             1,64'h3008,0,32'h0, 64'h0,   0);
    add(0,0,1,dk(7),  0,64'h0,             0,64'h0,   1,lo(7), 64'h3008,0);
    add(0,1,0,64'h0,  1,64'hFFFF_FFFF_FFFF_FFFE, 0,64'h0, 0,32'h0, 64'h0, 1);
    add(0,1,0,64'h0,  0,64'h0,             1,64'hFFFF_FFFF_FFFF_FFF8, 0,32'h0, 64'h0, 0);
    add(0,0,1,dk(8),  0,64'h0,             0,64'h0,   1,hi(8), 64'hFFFF_FFFF_FFFF_FFFC, 0);
    add(1,1,0,64'h0,  0,64'h0,             0,64'h0,   0,32'h0, 64'h0,   0);
    add(0,1,0,64'h0,  0,64'h0,             1,64'h0,   0,32'h0, 64'h0,   0);

    do_reset();
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].full, vecs[i].gnt, vecs[i].vld, vecs[i].data,
            vecs[i].redir, vecs[i].tgt);
      #1 chk($sformatf("vec%0d", i), act(),
             {vecs[i].ereq, vecs[i].eaddr, vecs[i].een, vecs[i].einsn,
              vecs[i].epc, vecs[i].eflush});
      @(negedge clk);
    end

    // Reset while in WAIT with a response arriving: everything must go quiet.
    drive(0, 0, 1, dk(9), 0, 64'h0);
    rst_n = 1'b0;
    #1 chk("rst_async", act(), 163'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 1, dk(10), 0, 64'h0);
    #1 chk("stale_vld_after_rst", act(), 163'h0);
    @(negedge clk);
    drive(0, 0, 0, 64'h0, 0, 64'h0);
    #1 chk("restart_pc", act(), {1'b1, 64'h100, 1'b0, 32'h0, 64'h0, 1'b0});
    @(negedge clk);

    // Randomized traffic against the model.
    do_reset();
    m_started = 0; m_busy = 0; m_stale = 0; m_held = 0;
    m_pc = 64'h100; m_hpc = 0; m_hinsn = 0;
    s_pend = 0; s_wait = 0;
    for (int c = 0; c < 4000; c++) begin
      f = ($urandom_range(0, 3) == 0);
      g = ($urandom_range(0, 1) == 1);
      r = ($urandom_range(0, 15) == 0);
      d = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) t = {32'hFFFF_FFFF, 28'hFFF_FFFF, 4'($urandom)};
      else t = {$urandom, $urandom};
      v = 0;
      if (s_pend) begin
        if (s_wait == 0) begin v = 1; s_pend = 0; end
        else s_wait--;
      end else if ($urandom_range(0, 9) == 0) v = 1;
      drive(f, g, v, d, r, t);

      ereq = 0; een = 0; einsn = 0; epc = 0; eaddr = 0;
      if (!m_started) begin
        m_started = 1;
        if (r) m_pc = {t[63:2], 2'b00};
      end else if (m_held) begin
        if (!f && !r) begin een = 1; einsn = m_hinsn; epc = m_hpc; end
        if (r) begin m_held = 0; m_pc = {t[63:2], 2'b00}; end
        else if (!f) begin m_held = 0; m_pc = m_hpc + 4; end
      end else if (m_busy) begin
        m_busy = !v && !r;
        if (r) begin
          m_stale = !v;
          m_pc = {t[63:2], 2'b00};
        end else if (v && !f) begin
          een = 1; einsn = pick(m_pc, d); epc = m_pc; m_pc = m_pc + 4;
        end else if (v) begin
          m_held = 1; m_hinsn = pick(m_pc, d); m_hpc = m_pc;
        end
      end else if (m_stale) begin
        if (v) m_stale = 0;
        if (r) m_pc = {t[63:2], 2'b00};
      end else begin
        ereq = !f && !r;
        if (ereq) eaddr = m_pc & ~64'h7;
        if (ereq && g) begin
          m_busy = 1; s_pend = 1; s_wait = $urandom_range(0, 3);
        end
        if (r) m_pc = {t[63:2], 2'b00};
      end

      #1 chk($sformatf("rand%0d", c), act(), {ereq, eaddr, een, einsn, epc, r});
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/if_fetch_ctrl.md
# if_fetch_ctrl

Fetch sequencer in the IF stage, in front of the instruction fetch buffer. Owns the architectural fetch PC and issues one I-cache request at a time. Selects the 32-bit instruction from the returned 64-bit block and writes it into the fetch buffer. Applies back-pressure from the buffer's full flag and branch redirects, including discarding in-flight responses after a flush.

## Interface
- RESET_PC, 64'h0, fetch PC loaded on reset
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- icache_req_o  out  1  fetch request valid
- icache_addr_o  out  64  request address, {PC[63:3],3'b000}
- icache_gnt_i  in  1  request accepted this cycle
- icache_vld_i  in  1  response valid, one cycle per granted request
- icache_data_i  in  64  response block
- br_redirect_i  in  1  branch mispredict/redirect, one-cycle pulse
- br_target_i  in  64  redirect target PC
- ifb_full_i  in  1  fetch buffer full
- ifb_en_o  out  1  write strobe to fetch buffer
- ifb_insn_o  out  32  instruction to buffer
- ifb_PC_o  out  64  PC of ifb_insn_o
- ifb_flush_o  out  1  flush to fetch buffer

## Operation
- States: IDLE, REQ, WAIT, DRAIN, HOLD. Reset: state=IDLE, PC=RESET_PC, hold regs=0, all outputs 0.
- IDLE: go to REQ unconditionally on the next edge.
- REQ: icache_req_o = ~ifb_full_i & ~br_redirect_i.
  - Req & gnt: go to WAIT.
  - Otherwise: stay in REQ.
- WAIT: on icache_vld_i, instruction = PC[2] ? data[63:32] : data[31:0].
  - Buffer not full: ifb_en_o=1 in the same cycle, PC<=PC+4, go to REQ.
  - Buffer full: latch instruction and PC, go to HOLD.
- HOLD: when ~ifb_full_i, ifb_en_o=1 with the held instruction/PC, PC<=PC+4, go to REQ.
- DRAIN: wait for icache_vld_i, discard the response (ifb_en_o=0), go to REQ.
- Redirect (any state except IDLE):
  - ifb_flush_o = br_redirect_i, combinational, same cycle.
  - PC<={br_target_i[63:2],2'b00}.
  - ifb_en_o is forced 0 that cycle.
  - Next state:
    - WAIT without vld: DRAIN.
    - WAIT with vld: REQ, response dropped.
    - REQ with gnt: cannot occur, since the request is masked during a redirect.
    - HOLD: REQ, held instruction dropped.
    - DRAIN: stay in DRAIN.
    - REQ: stay in REQ.
- Redirect in IDLE: PC updated, go to REQ, ifb_flush_o=1.
- PC arithmetic is 64-bit modulo 2^64; PC 64'hFFFF_FFFF_FFFF_FFFC + 4 wraps to 0.
- At most one request outstanding; icache_vld_i outside WAIT/DRAIN is ignored.

## Timing
- ifb_en_o, ifb_insn_o, ifb_PC_o, icache_req_o and ifb_flush_o are combinational from state, registers and inputs.
- When ifb_en_o=0, ifb_insn_o/ifb_PC_o are 0.
- Best-case throughput: grant in cycle t, vld in t+1, buffer write in t+1, next request in t+2 (one instruction per 2 cycles).
- Response latency is unbounded; the block waits in WAIT/DRAIN indefinitely.
- Redirect to first request with the new PC: the next cycle in which the state is REQ and the buffer is not full.
- rst_n assertion mid-operation returns to IDLE immediately and asynchronously; any outstanding response arriving after reset release is ignored (state is IDLE/REQ).

## Configuration
- IF_FETCH_CTRL_PERF_EN defined: adds two output ports.
  - perf_fetch_cnt_o (32): counts ifb_en_o cycles.
  - perf_stall_cnt_o (32): counts cycles in REQ or HOLD with ifb_full_i=1.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- Not defined: ports and counters absent; behaviour otherwise identical.

## Test plan
- Reset with RESET_PC=64'h100; gnt and vld each one cycle after request -> ifb writes PC 0x100, 0x104, 0x108. Instructions come from data[31:0], data[63:32], data[31:0].
- ifb_full_i=1 while in WAIT, then vld at PC 0x104 -> HOLD, ifb_en_o=0. Release full 3 cycles later -> single write with PC 0x104 and data[63:32].
- Redirect to 64'h2003 while in WAIT with vld 2 cycles later:
  - ifb_flush_o=1 on the redirect cycle.
  - The late response is discarded.
  - Next icache_addr_o=0x2000 and ifb_PC_o=0x2000.
- Redirect coincident with vld -> no buffer write; next request uses the target.
- PC=64'hFFFF_FFFF_FFFF_FFFC fetch -> next icache_addr_o=0.
- rst_n pulsed low during WAIT -> outputs 0 immediately; a stale vld after release produces no ifb_en_o; fetch restarts at RESET_PC.
